pipe_tag_tracker: RTL and testbench

PIPE_TAG_TRACKER -- requirements
Module: pipe_tag_tracker

---
 rtl/pipe_tag_tracker.sv | 193 +++++++++++++++++++
 tb/tb_pipe_tag_tracker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_tag_tracker.sv
// Shadow tag tracker for a 4-stage pipeline.
// Each fetched instruction gets a sequential tag and is followed through IF/ID, ID/EX, EX/MEM and MEM/WB.
// Every valid MEM/WB slot produces a retire record in a small FIFO.
// The FIFO head is presented on registered retire_* outputs.
module pipe_tag_tracker #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ID_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  fetch_pc,
    input  logic [15:0]                  fetch_instr,
    input  logic                         stall,
    input  logic                         IF_flush,
    input  logic                         ID_flush,
    input  logic                         retire_ready,
    output logic                         retire_valid,
    output logic [ID_W-1:0]              retire_id,
    output logic [15:0]                  retire_pc,
    output logic [15:0]                  retire_instr,
    output logic [15:0]                  retire_fetch_cyc,
    output logic [15:0]                  retire_wb_cyc,
    output logic [15:0]                  cycle_cnt,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [15:0]     pc;
        logic [15:0]     instr;
        logic [15:0]     fetch_cyc;
    } stage_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [15:0]     pc;
        logic [15:0]     instr;
        logic [15:0]     fetch_cyc;
        logic [15:0]     wb_cyc;
    } rec_t;

    stage_t          if_id;
    stage_t          id_ex;
    stage_t          ex_mem;
    stage_t          mem_wb;
    logic [15:0]     mem_wb_cyc;
    logic [ID_W-1:0] next_id;

    rec_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after_pop;
    logic [CNT_W-1:0] count_nxt;

    logic            fetch_take;
    logic            push;
    logic            pop;
    logic            full;
    logic            push_ok;
    logic            drop;
    rec_t            push_rec;
    rec_t            head_nxt;

    // Free-running cycle counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= 16'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    // A new fetch is tagged only when IF/ID actually captures it
    always_comb begin
        fetch_take = !IF_flush && !stall;
    end

    // IF/ID shadow register and tag allocator; a flush beats a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id   <= '0;
            next_id <= '0;
        end else if (IF_flush) begin
            if_id   <= '0;
        end else if (fetch_take) begin
            if_id   <= '{valid: 1'b1, id: next_id, pc: fetch_pc,
                         instr: fetch_instr, fetch_cyc: cycle_cnt};
            next_id <= next_id + ID_W'(1);
        end
    end

    // ID/EX takes a bubble on a load-use stall or a decode flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex <= '0;
        end else if (stall || ID_flush) begin
            id_ex <= '0;
        end else begin
            id_ex <= if_id;
        end
    end

    // EX/MEM and MEM/WB always advance; MEM/WB remembers the cycle it was entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem     <= '0;
            mem_wb     <= '0;
            mem_wb_cyc <= 16'd0;
        end else begin
            ex_mem     <= id_ex;
            mem_wb     <= ex_mem;
            mem_wb_cyc <= cycle_cnt;
        end
    end

    // FIFO control: push/pop qualification and the next head record
    always_comb begin
        push            = mem_wb.valid;
        full            = (count == CNT_W'(FIFO_DEPTH));
        pop             = retire_valid && retire_ready;
        push_ok         = push && (!full || pop);
        drop            = push && full && !pop;
        push_rec        = '{id: mem_wb.id, pc: mem_wb.pc, instr: mem_wb.instr,
                            fetch_cyc: mem_wb.fetch_cyc, wb_cyc: mem_wb_cyc};
        rd_ptr_nxt      = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_after_pop = pop ? count - CNT_W'(1) : count;
        count_nxt       = push_ok ? count_after_pop + CNT_W'(1) : count_after_pop;
        head_nxt        = '0;
        if (count_after_pop != '0) begin
            head_nxt = mem[rd_ptr_nxt];
        end else if (push_ok) begin
            head_nxt = push_rec;
        end
    end

    // Record storage; contents are only meaningful between rd_ptr and wr_ptr
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_rec;
        end
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Registered head presentation; zeros whenever the FIFO is empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_valid     <= 1'b0;
            retire_id        <= '0;
            retire_pc        <= 16'd0;
            retire_instr     <= 16'd0;
            retire_fetch_cyc <= 16'd0;
            retire_wb_cyc    <= 16'd0;
        end else begin
            retire_valid     <= (count_nxt != '0);
            retire_id        <= head_nxt.id;
            retire_pc        <= head_nxt.pc;
            retire_instr     <= head_nxt.instr;
            retire_fetch_cyc <= head_nxt.fetch_cyc;
            retire_wb_cyc    <= head_nxt.wb_cyc;
        end
    end

    // Occupancy is exported directly from the count register
    always_comb begin
        fifo_count = count;
    end

endmodule

// File: tb/tb_pipe_tag_tracker.sv
// Bench for pipe_tag_tracker: per-instruction lifetime model plus directed scenarios.
module tb_pipe_tag_tracker;

    localparam int DEPTH = 4;
    localparam int IDW   = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] fetch_pc;
    logic [15:0] fetch_instr;
    logic        stall;
    logic        IF_flush;
    logic        ID_flush;
    logic        retire_ready;
    logic        retire_valid;
    logic [7:0]  retire_id;
    logic [15:0] retire_pc;
    logic [15:0] retire_instr;
    logic [15:0] retire_fetch_cyc;
    logic [15:0] retire_wb_cyc;
    logic [15:0] cycle_cnt;
    logic [2:0]  fifo_count;
    logic        overflow;

    pipe_tag_tracker #(.FIFO_DEPTH(DEPTH), .ID_W(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .stall(stall), .IF_flush(IF_flush), .ID_flush(ID_flush),
        .retire_ready(retire_ready), .retire_valid(retire_valid),
        .retire_id(retire_id), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .retire_fetch_cyc(retire_fetch_cyc), .retire_wb_cyc(retire_wb_cyc),
        .cycle_cnt(cycle_cnt), .fifo_count(fifo_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each live instruction carries its stage number (0=IF/ID .. 3=MEM/WB).
    typedef struct {
        int st;
        int id;
        int pc;
        int instr;
        int fcyc;
        int wcyc;
    } mrec_t;

    mrec_t inflight[$];
    mrec_t q[$];
    mrec_t m_nxt[$];
    mrec_t m_r;
    mrec_t m_ret;
    bit    m_got;
    int    m_cyc = 0;
    int    m_nid = 0;
    bit    m_ovf = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            inflight.delete();
            q.delete();
            m_cyc = 0;
            m_nid = 0;
            m_ovf = 0;
        end else begin
            m_nxt.delete();
            m_got = 0;
            foreach (inflight[i]) begin
                m_r = inflight[i];
                if (m_r.st == 3) begin
                    m_ret = m_r;
                    m_got = 1;
                end else if (m_r.st == 2) begin
                    m_r.st = 3;
                    m_r.wcyc = m_cyc;
                    m_nxt.push_back(m_r);
                end else if (m_r.st == 1) begin
                    m_r.st = 2;
                    m_nxt.push_back(m_r);
                end else begin
                    if (stall && !IF_flush) begin
                        m_nxt.push_back(m_r);
                    end else if (!stall && !ID_flush) begin
                        m_r.st = 1;
                        m_nxt.push_back(m_r);
                    end
                end
            end
            if (!stall && !IF_flush) begin
                m_r.st = 0; m_r.id = m_nid; m_r.pc = fetch_pc; m_r.instr = fetch_instr;
                m_r.fcyc = m_cyc; m_r.wcyc = 0;
                m_nxt.push_back(m_r);
                m_nid = (m_nid + 1) % (1 << IDW);
            end
            if (q.size() > 0 && retire_ready) void'(q.pop_front());
            if (m_got) begin
                if (q.size() < DEPTH) q.push_back(m_ret);
                else m_ovf = 1;
            end
            inflight = m_nxt;
            m_cyc = (m_cyc + 1) & 16'hFFFF;
        end
    end

    // ---------------- per-cycle comparison ----------------
    int last_head = -1;
    bit wrap_seen = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cycle_cnt", cycle_cnt, m_cyc);
            chk("fifo_count", fifo_count, q.size());
            chk("overflow", overflow, m_ovf);
            chk("retire_valid", retire_valid, (q.size() > 0));
            if (q.size() > 0 && retire_valid) begin
                chk("retire_id", retire_id, q[0].id);
                chk("retire_pc", retire_pc, q[0].pc);
                chk("retire_instr", retire_instr, q[0].instr);
                chk("retire_fetch_cyc", retire_fetch_cyc, q[0].fcyc);
                chk("retire_wb_cyc", retire_wb_cyc, q[0].wcyc);
            end
            if (retire_valid) begin
                if (last_head >= 200 && retire_id == 8'd0) wrap_seen = 1;
                last_head = retire_id;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] pc;

    task automatic step(input logic s, input logic fi, input logic fd, input logic rr);
        stall = s; IF_flush = fi; ID_flush = fd; retire_ready = rr;
        fetch_pc = pc; fetch_instr = pc ^ 16'h5A00;
        @(posedge clk);
        if (fi) pc = 16'h0100;
        else if (!s) pc = pc + 16'd2;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        rst_n = 1'b0; stall = 1'b0; IF_flush = 1'b0; ID_flush = 1'b0; retire_ready = 1'b1;
        pc = 16'd0; fetch_pc = 16'd0; fetch_instr = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_valid", retire_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_cyc", cycle_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_id", retire_id, 0);
        rst_n = 1'b1;

        // Startup, one-cycle stall on tag 3, branch flush at step 13
        for (int k = 1; k <= 19; k++) begin
            step(k == 5, k == 13, k == 13, 1'b1);
            if (k == 4) chk("a_empty4", retire_valid, 0);
            if (k == 5) begin
                chk("a_first_valid", retire_valid, 1);
                chk("a_first_id", retire_id, 0);
                chk("a_first_pc", retire_pc, 16'h0000);
                chk("a_first_instr", retire_instr, 16'h5A00);
                chk("a_lat", 16'(retire_wb_cyc - retire_fetch_cyc), 3);
            end
            if (k == 6) begin
                chk("a_id1", retire_id, 1);
                chk("a_cnt1", fifo_count, 1);
            end
            if (k == 7) chk("b_id2", retire_id, 2);
            if (k == 8) chk("b_gap", retire_valid, 0);
            if (k == 9) begin
                chk("b_id3", retire_id, 3);
                chk("b_lat3", 16'(retire_wb_cyc - retire_fetch_cyc), 4);
            end
            if (k == 15) chk("c_id9", retire_id, 9);
            if (k == 16) chk("c_bubble1", retire_valid, 0);
            if (k == 17) chk("c_bubble2", retire_valid, 0);
            if (k == 18) begin
                chk("c_id11", retire_id, 11);
                chk("c_pc11", retire_pc, 16'h0100);
            end
            if (k == 19) chk("c_id12", retire_id, 12);
        end

        // Back-pressure: consumer stalls for 6 cycles
        for (int k = 20; k <= 25; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 22) begin
                chk("d_cnt_full", fifo_count, 4);
                chk("d_no_ovf_yet", overflow, 0);
            end
        end
        chk("d_cnt_sat", fifo_count, 4);
        chk("d_ovf", overflow, 1);
        chk("d_head", retire_id, 12);

        // Full FIFO with simultaneous push and pop
        for (int k = 26; k <= 29; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            chk("e_cnt", fifo_count, 4);
            if (k == 26) chk("e_id13", retire_id, 13);
            if (k == 29) chk("e_id19", retire_id, 19);
        end

        // Long run past the tag wrap with periodic stalls and ready drops
        for (int i = 0; i < 360; i++) begin
            step((i % 6) == 0, 1'b0, 1'b0, (i % 9) != 4);
        end
        chk("f_id_wrap", wrap_seen, 1);

        // Asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        chk("r_valid", retire_valid, 0);
        chk("r_id", retire_id, 0);
        chk("r_pc", retire_pc, 0);
        chk("r_instr", retire_instr, 0);
        chk("r_fcyc", retire_fetch_cyc, 0);
        chk("r_wcyc", retire_wb_cyc, 0);
        chk("r_cyc", cycle_cnt, 0);
        chk("r_cnt", fifo_count, 0);
        chk("r_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pc = 16'd0;
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            if (first < 0 && retire_valid) first = k;
            if (k == 5) chk("r_first_id", retire_id, 0);
        end
        chk("r_first_latency", first, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
